// File: rtl/branch_condition_unit.sv
// Branch resolver: evaluates ccc against committed {N,V,Z} flags and produces taken/next-PC/flush.
// Latency: result registered, 1 cycle after acceptance; 2 cycles when a flag write is in flight.
// Backpressure: br_ready drops for one cycle while a branch waits out an in-flight flag write.
module branch_condition_unit #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [2:0]        i_flags,
  input  logic [1:0]        i_flags_set_ex,
  input  logic              i_br_valid,
  output logic              o_br_ready,
  input  logic [2:0]        i_br_cond,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic [ADDR_W-1:0] i_pc_plus2,
  output logic              o_res_valid,
  output logic              o_res_taken,
  output logic [ADDR_W-1:0] o_res_next_pc,
  output logic              o_flush,
  output logic [CNT_W-1:0]  o_taken_cnt,
  output logic [CNT_W-1:0]  o_total_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Copy of a branch parked while the flag write lands
  logic [2:0]          r_cond;
  logic [ADDR_W-1:0]   r_target;
  logic [ADDR_W-1:0]   r_pc_plus2;

  logic                r_res_valid;
  logic                r_res_taken;
  logic [ADDR_W-1:0]   r_res_next_pc;
  logic [CNT_W-1:0]    r_taken_cnt;
  logic [CNT_W-1:0]    r_total_cnt;

  logic                w_br_ready;
  logic                w_latch;
  logic                w_eval_vld;
  logic [2:0]          w_eval_cond;
  logic [ADDR_W-1:0]   w_eval_target;
  logic [ADDR_W-1:0]   w_eval_pc_plus2;
  logic                w_eval_taken;

  // Only the Z/N/V write enable (bit 0) matters for stalling
  logic                w_unused_set_ex;
  assign w_unused_set_ex = i_flags_set_ex[1];

  // Condition table over {N,V,Z}
  function automatic logic cond_true(input logic [2:0] ccc, input logic [2:0] f);
    logic n, v, z;
    n = f[2];
    v = f[1];
    z = f[0];
    case (ccc)
      3'b000:  cond_true = !z;
      3'b001:  cond_true = z;
      3'b010:  cond_true = !z && !n;
      3'b011:  cond_true = n;
      3'b100:  cond_true = z || !n;
      3'b101:  cond_true = n || z;
      3'b110:  cond_true = v;
      default: cond_true = 1'b1;
    endcase
  endfunction

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, handshake and selection of which branch gets evaluated this cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_br_ready      = 1'b0;
    w_latch         = 1'b0;
    w_eval_vld      = 1'b0;
    w_eval_cond     = i_br_cond;
    w_eval_target   = i_br_target;
    w_eval_pc_plus2 = i_pc_plus2;
    case (r_state)
      S_IDLE: begin
        w_br_ready = !(i_br_valid && i_flags_set_ex[0]);
        if (i_br_valid) begin
          if (i_flags_set_ex[0]) begin
            w_latch     = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_eval_vld = 1'b1;
          end
        end
      end
      S_HOLD: begin
        // Flags were updated at the edge that entered HOLD, so i_flags is now current
        w_eval_vld      = 1'b1;
        w_eval_cond     = r_cond;
        w_eval_target   = r_target;
        w_eval_pc_plus2 = r_pc_plus2;
        w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_eval_taken = cond_true(w_eval_cond, i_flags);

  // Park the stalled branch
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cond     <= '0;
      r_target   <= '0;
      r_pc_plus2 <= '0;
    end else if (w_latch) begin
      r_cond     <= i_br_cond;
      r_target   <= i_br_target;
      r_pc_plus2 <= i_pc_plus2;
    end
  end

  // Result register: valid pulses, taken/next-PC hold their last value
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_next_pc <= '0;
    end else begin
      r_res_valid <= w_eval_vld;
      if (w_eval_vld) begin
        r_res_taken   <= w_eval_taken;
        r_res_next_pc <= w_eval_taken ? w_eval_target : w_eval_pc_plus2;
      end
    end
  end

  // Saturating statistics, updated together with the result so they track res_valid
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_taken_cnt <= '0;
      r_total_cnt <= '0;
    end else if (w_eval_vld) begin
      if (r_total_cnt != '1) r_total_cnt <= r_total_cnt + CNT_W'(1);
      if (w_eval_taken && (r_taken_cnt != '1)) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign o_br_ready    = w_br_ready;
  assign o_res_valid   = r_res_valid;
  assign o_res_taken   = r_res_taken;
  assign o_res_next_pc = r_res_next_pc;
  assign o_flush       = r_res_valid & r_res_taken;
  assign o_taken_cnt   = r_taken_cnt;
  assign o_total_cnt   = r_total_cnt;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Directed bench for branch_condition_unit.
// Inputs change away from the rising edge; outputs are sampled 1 ns after it.
// A single summary line reports check and error counts.
module tb_branch_condition_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  flags;
  logic [1:0]  flags_set_ex;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [15:0] pc_plus2;
  logic        res_valid;
  logic        res_taken;
  logic [15:0] res_next_pc;
  logic        flush;
  logic [15:0] taken_cnt;
  logic [15:0] total_cnt;

  int n_checks = 0;
  int n_errors = 0;

  branch_condition_unit #(.ADDR_W(16), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flags        (flags),
    .i_flags_set_ex (flags_set_ex),
    .i_br_valid     (br_valid),
    .o_br_ready     (br_ready),
    .i_br_cond      (br_cond),
    .i_br_target    (br_target),
    .i_pc_plus2     (pc_plus2),
    .o_res_valid    (res_valid),
    .o_res_taken    (res_taken),
    .o_res_next_pc  (res_next_pc),
    .o_flush        (flush),
    .o_taken_cnt    (taken_cnt),
    .o_total_cnt    (total_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference condition table, written straight from the ccc definitions
  function automatic logic ref_taken(input logic [2:0] ccc, input logic [2:0] f);
    logic n, v, z;
    n = f[2]; v = f[1]; z = f[0];
    case (ccc)
      3'd0: return (z == 1'b0);
      3'd1: return (z == 1'b1);
      3'd2: return (z == 1'b0) && (n == 1'b0);
      3'd3: return (n == 1'b1);
      3'd4: return (z == 1'b1) || ((z == 1'b0) && (n == 1'b0));
      3'd5: return (n == 1'b1) || (z == 1'b1);
      3'd6: return (v == 1'b1);
      default: return 1'b1;
    endcase
  endfunction

  initial begin : stim
    logic [5:0]  idx;
    logic        exp_t;
    int          exp_taken_sum;
    logic [2:0]  b2b_cond [4];
    logic        b2b_exp  [4];

    rst = 1'b0; flags = 3'b000; flags_set_ex = 2'b00; br_valid = 1'b0;
    br_cond = 3'b000; br_target = 16'h0000; pc_plus2 = 16'h0000;

    // Reset state
    #2;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_taken", {31'd0, res_taken}, 32'd0);
    chk("rst_next_pc", {16'd0, res_next_pc}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("rst_total_cnt", {16'd0, total_cnt}, 32'd0);
    chk("rst_br_ready", {31'd0, br_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // 1: EQ taken, no pending flag write
    flags = 3'b001; br_cond = 3'b001; flags_set_ex = 2'b00;
    br_target = 16'h0040; pc_plus2 = 16'h0012; br_valid = 1'b1;
    #1;
    chk("t1_br_ready", {31'd0, br_ready}, 32'd1);
    @(posedge clk); #1;
    br_valid = 1'b0;
    chk("t1_res_valid", {31'd0, res_valid}, 32'd1);
    chk("t1_res_taken", {31'd0, res_taken}, 32'd1);
    chk("t1_next_pc", {16'd0, res_next_pc}, 32'h0040);
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_total", {16'd0, total_cnt}, 32'd1);
    chk("t1_taken", {16'd0, taken_cnt}, 32'd1);
    @(posedge clk); #1;
    chk("t1_valid_pulse", {31'd0, res_valid}, 32'd0);
    chk("t1_flush_pulse", {31'd0, flush}, 32'd0);
    chk("t1_taken_hold", {31'd0, res_taken}, 32'd1);
    chk("t1_pc_hold", {16'd0, res_next_pc}, 32'h0040);

    // 2: stall behind a flag write that sets Z; NE then false
    flags = 3'b000; flags_set_ex = 2'b11; br_cond = 3'b000;
    br_target = 16'h0080; pc_plus2 = 16'h0022; br_valid = 1'b1;
    #1;
    chk("t2_br_ready_stall", {31'd0, br_ready}, 32'd0);
    @(posedge clk); #1;
    flags = 3'b001; br_valid = 1'b0; br_cond = 3'b111; br_target = 16'hDEAD;
    #1;
    chk("t2_br_ready_hold", {31'd0, br_ready}, 32'd0);
    chk("t2_no_valid_n1", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    flags_set_ex = 2'b00;
    chk("t2_res_valid_n2", {31'd0, res_valid}, 32'd1);
    chk("t2_res_taken", {31'd0, res_taken}, 32'd0);
    chk("t2_next_pc", {16'd0, res_next_pc}, 32'h0022);
    chk("t2_flush", {31'd0, flush}, 32'd0);
    chk("t2_total", {16'd0, total_cnt}, 32'd2);
    chk("t2_taken", {16'd0, taken_cnt}, 32'd1);
    chk("t2_br_ready_idle", {31'd0, br_ready}, 32'd1);

    // 3: full ccc x flags sweep from cleared counters
    rst = 1'b0;
    #3;
    rst = 1'b1;
    exp_taken_sum = 0;
    flags_set_ex = 2'b00;
    for (int i = 0; i < 64; i++) begin
      idx = 6'(i);
      br_cond = idx[5:3]; flags = idx[2:0];
      br_target = {8'hA0, 2'b00, idx}; pc_plus2 = {8'h50, 2'b00, idx};
      br_valid = 1'b1;
      exp_t = ref_taken(idx[5:3], idx[2:0]);
      if (exp_t) exp_taken_sum++;
      @(posedge clk); #1;
      chk("t3_res_valid", {31'd0, res_valid}, 32'd1);
      chk($sformatf("t3_taken_c%0d_f%0d", idx[5:3], idx[2:0]), {31'd0, res_taken}, {31'd0, exp_t});
      chk("t3_next_pc", {16'd0, res_next_pc},
          exp_t ? {16'd0, 8'hA0, 2'b00, idx} : {16'd0, 8'h50, 2'b00, idx});
    end
    br_valid = 1'b0;
    chk("t3_total", {16'd0, total_cnt}, 32'd64);
    chk("t3_taken_hand", {16'd0, taken_cnt}, 32'd38);
    chk("t3_taken_model", {16'd0, taken_cnt}, 32'(exp_taken_sum));

    // 4: saturation from a preloaded FFFE
    @(negedge clk);
    force dut.r_taken_cnt = 16'hFFFE;
    force dut.r_total_cnt = 16'hFFFE;
    #1;
    release dut.r_taken_cnt;
    release dut.r_total_cnt;
    br_cond = 3'b111; flags = 3'b000; br_target = 16'h1234; pc_plus2 = 16'h5678;
    br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t4_taken_sat", {16'd0, taken_cnt}, 32'h0000FFFF);
      chk("t4_total_sat", {16'd0, total_cnt}, 32'h0000FFFF);
    end
    br_valid = 1'b0;

    // 5: async reset while a branch is parked in HOLD
    flags_set_ex = 2'b01; br_cond = 3'b111; br_target = 16'h7777; br_valid = 1'b1;
    @(posedge clk); #1;
    br_valid = 1'b0;
    chk("t5_in_hold", {31'd0, br_ready}, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_rst_taken", {31'd0, res_taken}, 32'd0);
    chk("t5_rst_pc", {16'd0, res_next_pc}, 32'd0);
    chk("t5_rst_flush", {31'd0, flush}, 32'd0);
    chk("t5_rst_taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("t5_rst_total_cnt", {16'd0, total_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    flags_set_ex = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_no_valid", {31'd0, res_valid}, 32'd0);
      chk("t5_total_zero", {16'd0, total_cnt}, 32'd0);
    end

    // 6: four back-to-back branches with N=1
    b2b_cond[0] = 3'b011; b2b_exp[0] = 1'b1;
    b2b_cond[1] = 3'b000; b2b_exp[1] = 1'b1;
    b2b_cond[2] = 3'b001; b2b_exp[2] = 1'b0;
    b2b_cond[3] = 3'b010; b2b_exp[3] = 1'b0;
    flags = 3'b100;
    for (int i = 0; i < 4; i++) begin
      br_cond = b2b_cond[i];
      br_target = 16'h0100 + 16'(i);
      pc_plus2 = 16'h0200 + 16'(i);
      br_valid = 1'b1;
      #1;
      chk("t6_br_ready", {31'd0, br_ready}, 32'd1);
      @(posedge clk); #1;
      chk("t6_res_valid", {31'd0, res_valid}, 32'd1);
      chk($sformatf("t6_taken_%0d", i), {31'd0, res_taken}, {31'd0, b2b_exp[i]});
      chk("t6_flush", {31'd0, flush}, {31'd0, b2b_exp[i]});
      chk("t6_next_pc", {16'd0, res_next_pc},
          b2b_exp[i] ? 32'h0100 + 32'(i) : 32'h0200 + 32'(i));
    end
    br_valid = 1'b0;
    chk("t6_total", {16'd0, total_cnt}, 32'd4);
    chk("t6_taken", {16'd0, taken_cnt}, 32'd2);
    @(posedge clk); #1;
    chk("t6_valid_end", {31'd0, res_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
